// File: rtl/mem_access_pkg.sv
// Shared types and defaults for the mem_access_ctrl sequencing front-end.
package mem_access_pkg;

    localparam int unsigned DefDw           = 64;
    localparam int unsigned DefAw           = 6;
    localparam int unsigned DefAccessCycles = 2;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StTurn,
        StResp
    } state_e;

    // Strobe counter runs ACCESS_CYCLES-1 down to 0.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles < 3) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response channel bundle between a requester and mem_access_ctrl.
interface mem_access_ctrl_if #(
    parameter int unsigned DW = 64,
    parameter int unsigned AW = 6
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_bus_drv.sv
// Tri-state driver and sample path for the shared memory DataBus.
module mem_bus_drv #(
    parameter int unsigned DW = 64
) (
    input  logic          oe_i,
    input  logic [DW-1:0] dout_i,
    output logic [DW-1:0] din_o,
    inout  wire  [DW-1:0] dbus_io
);
    assign dbus_io = oe_i ? dout_i : {DW{1'bz}};
    assign din_o   = dbus_io;
endmodule

// File: rtl/mem_access_ctrl.sv
// Sequencer for a 64x64 async memory: SETUP/STROBE/TURN timing around one access at a time.
// Optional write-verify readback is enabled with `define MEM_ACCESS_WRVERIFY_EN.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int unsigned DW            = DefDw,
    parameter int unsigned AW            = DefAw,
    parameter int unsigned ACCESS_CYCLES = DefAccessCycles
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_access_ctrl_if.slave bus,
    output logic            MemRd,
    output logic            MemWr,
    output logic [AW-1:0]   Addr,
    inout  wire  [DW-1:0]   DataBus
);
    localparam int unsigned     CntW    = cnt_width(ACCESS_CYCLES);
    localparam logic [CntW-1:0] CntLoad = CntW'(ACCESS_CYCLES - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            rd_q, rd_d;
    logic            wr_q, wr_d;
    logic            oe_q, oe_d;
    logic            req_ready_q, req_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [DW-1:0]   din;
`ifdef MEM_ACCESS_WRVERIFY_EN
    logic            verify_q, verify_d;
`endif

    mem_bus_drv #(
        .DW (DW)
    ) u_bus_drv (
        .oe_i    (oe_q),
        .dout_i  (wdata_q),
        .din_o   (din),
        .dbus_io (DataBus)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        oe_d        = oe_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
`ifdef MEM_ACCESS_WRVERIFY_EN
        verify_d    = verify_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (bus.req_valid && req_ready_q) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    oe_d    = bus.req_we;
                    state_d = StSetup;
`ifdef MEM_ACCESS_WRVERIFY_EN
                    verify_d = 1'b0;
`endif
                end
            end
            StSetup: begin
                state_d = StStrobe;
                cnt_d   = CntLoad;
`ifdef MEM_ACCESS_WRVERIFY_EN
                wr_d = we_q && !verify_q;
                rd_d = !we_q || verify_q;
`else
                wr_d = we_q;
                rd_d = !we_q;
`endif
            end
            StStrobe: begin
                if (cnt_q == '0) begin
                    state_d = StTurn;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    oe_d    = 1'b0;
                    // Data is sampled on the edge that drops MemRd, while memory still drives.
                    rdata_d = rd_q ? din : '0;
`ifdef MEM_ACCESS_WRVERIFY_EN
                    err_d = verify_q && (din != wdata_q);
`else
                    err_d = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StTurn: begin
`ifdef MEM_ACCESS_WRVERIFY_EN
                if (we_q && !verify_q) begin
                    verify_d = 1'b1;
                    state_d  = StSetup;
                end else begin
                    state_d     = StResp;
                    rsp_valid_d = 1'b1;
                end
`else
                state_d     = StResp;
                rsp_valid_d = 1'b1;
`endif
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        req_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            oe_q        <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
`ifdef MEM_ACCESS_WRVERIFY_EN
            verify_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            oe_q        <= oe_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
`ifdef MEM_ACCESS_WRVERIFY_EN
            verify_q    <= verify_d;
`endif
        end
    end

    assign MemRd         = rd_q;
    assign MemWr         = wr_q;
    assign Addr          = addr_q;
    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl with an async memory model and an array reference.
module tb_mem_access_ctrl;
    localparam int unsigned AC = 2;
`ifdef MEM_ACCESS_WRVERIFY_EN
    localparam bit Verify = 1'b1;
`else
    localparam bit Verify = 1'b0;
`endif
    localparam int WrLat = Verify ? 2 * AC + 4 : AC + 2;
    localparam int RdLat = AC + 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_rd, mem_wr;
    logic [5:0]  addr;
    wire  [63:0] data_bus;

    mem_access_ctrl_if #(.DW(64), .AW(6)) bus_if ();

    mem_access_ctrl #(
        .DW            (64),
        .AW            (6),
        .ACCESS_CYCLES (AC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus_if),
        .MemRd   (mem_rd),
        .MemWr   (mem_wr),
        .Addr    (addr),
        .DataBus (data_bus)
    );

    always #5 clk = ~clk;

    // Async memory model; read path can flip bit 0 at one address to emulate a bad cell.
    logic [63:0] mem [64];
    logic [63:0] ref_mem [64];
    logic        corrupt_en = 1'b0;
    logic [5:0]  corrupt_addr = 6'h07;
    logic [63:0] rd_val;

    assign rd_val   = mem[addr] ^ ((corrupt_en && addr == corrupt_addr) ? 64'h1 : 64'h0);
    assign data_bus = mem_rd ? rd_val : {64{1'bz}};

    always @(negedge clk) if (mem_wr) mem[addr] <= data_bus;

    logic bus_oe;
    assign bus_oe = dut.u_bus_drv.oe_i;

    int         checks = 0;
    int         errors = 0;
    int         viol = 0;
    int         wr_cnt = 0;
    int         rd_cnt = 0;
    logic [5:0] cur_addr = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd && mem_wr) viol++;
            if (mem_rd && bus_oe) viol++;
            if ((bus_if.req_ready || bus_if.rsp_valid) && bus_oe) viol++;
            if ((mem_rd || mem_wr) && addr !== cur_addr) viol++;
            if (mem_wr) wr_cnt++;
            if (mem_rd) rd_cnt++;
        end
    end

    task automatic issue(input logic we, input logic [5:0] a, input logic [63:0] d,
                         output int lat, output logic [63:0] rdata, output logic err,
                         output int wrs, output int rds, output bit ok);
        int n = 0;
        int w0, r0;
        ok  = 1'b1;
        lat = 0;
        cur_addr = a;
        @(negedge clk);
        while (!bus_if.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus_if.req_ready) ok = 1'b0;
        w0 = wr_cnt;
        r0 = rd_cnt;
        bus_if.req_valid = 1'b1;
        bus_if.req_we    = we;
        bus_if.req_addr  = a;
        bus_if.req_wdata = d;
        @(posedge clk);
        #1 bus_if.req_valid = 1'b0;
        while (!bus_if.rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus_if.rsp_valid) ok = 1'b0;
        @(negedge clk);
        rdata = bus_if.rsp_rdata;
        err   = bus_if.rsp_err;
        wrs   = wr_cnt - w0;
        rds   = rd_cnt - r0;
        bus_if.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus_if.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus_if.req_valid = 1'b1;
        bus_if.req_we    = 1'b1;
        bus_if.req_addr  = 6'h15;
        bus_if.req_wdata = 64'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus_if.req_ready !== 1'b0 || mem_rd !== 1'b0 || mem_wr !== 1'b0 ||
                addr !== 6'h00 || bus_if.rsp_valid !== 1'b0 || bus_if.rsp_rdata !== 64'h0 ||
                bus_if.rsp_err !== 1'b0 || bus_oe !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d got rdy=%b rd=%b wr=%b a=%h v=%b d=%h e=%b oe=%b want all 0",
                         i, bus_if.req_ready, mem_rd, mem_wr, addr, bus_if.rsp_valid,
                         bus_if.rsp_rdata, bus_if.rsp_err, bus_oe);
            end
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1 bus_if.req_valid = 1'b0;
        checks++;
        if (bus_if.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %b want 1", bus_if.req_ready);
        end
        checks++;
        if (mem_wr !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_accept MemWr got %b want 0", mem_wr);
        end
        @(posedge clk);
        #1;
        checks++;
        if (mem_wr !== 1'b0 || bus_oe !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_accept2 MemWr/oe got %b/%b want 0/0", mem_wr, bus_oe);
        end
    endtask

    task automatic test_write_read();
        int lat, wrs, rds;
        logic [63:0] rd;
        logic er;
        bit ok;
        issue(1'b1, 6'h05, 64'h0123_4567_89AB_CDEF, lat, rd, er, wrs, rds, ok);
        ref_mem[5] = 64'h0123_4567_89AB_CDEF;
        checks++;
        if (!ok || lat !== WrLat) begin
            errors++;
            $display("FAIL wr_latency got %0d ok=%0d want %0d", lat, ok, WrLat);
        end
        checks++;
        if (wrs !== AC || rds !== (Verify ? AC : 0)) begin
            errors++;
            $display("FAIL wr_strobes got wr=%0d rd=%0d want wr=%0d rd=%0d",
                     wrs, rds, AC, Verify ? AC : 0);
        end
        checks++;
        if (rd !== (Verify ? ref_mem[5] : 64'h0) || er !== 1'b0) begin
            errors++;
            $display("FAIL wr_rsp got %h err=%b want %h err=0",
                     rd, er, Verify ? ref_mem[5] : 64'h0);
        end
        issue(1'b0, 6'h05, 64'h0, lat, rd, er, wrs, rds, ok);
        checks++;
        if (!ok || lat !== RdLat) begin
            errors++;
            $display("FAIL rd_latency got %0d ok=%0d want %0d", lat, ok, RdLat);
        end
        checks++;
        if (rd !== 64'h0123_4567_89AB_CDEF || er !== 1'b0 || rds !== AC || wrs !== 0) begin
            errors++;
            $display("FAIL rd_data got %h err=%b rd=%0d wr=%0d want 0123456789abcdef 0 %0d 0",
                     rd, er, rds, wrs, AC);
        end
    endtask

    task automatic test_backpressure();
        int lat, wrs, rds, n;
        logic [63:0] rd, held;
        logic er;
        bit ok;
        issue(1'b1, 6'h0A, 64'h0BAD_F00D_0000_000A, lat, rd, er, wrs, rds, ok);
        ref_mem[10] = 64'h0BAD_F00D_0000_000A;
        issue(1'b1, 6'h09, 64'h1111_2222_3333_4444, lat, rd, er, wrs, rds, ok);
        ref_mem[9] = 64'h1111_2222_3333_4444;
        cur_addr = 6'h09;
        @(negedge clk);
        bus_if.req_valid = 1'b1;
        bus_if.req_we    = 1'b0;
        bus_if.req_addr  = 6'h09;
        @(posedge clk);
        #1 bus_if.req_addr = 6'h0A;
        n = 0;
        while (!bus_if.rsp_valid && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        held = bus_if.rsp_rdata;
        checks++;
        if (bus_if.rsp_valid !== 1'b1 || held !== ref_mem[9]) begin
            errors++;
            $display("FAIL bp_first got v=%b d=%h want 1 %h", bus_if.rsp_valid, held, ref_mem[9]);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_rdata !== ref_mem[9] ||
                bus_if.req_ready !== 1'b0 || mem_rd !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cyc%0d got v=%b d=%h rdy=%b rd=%b want 1 %h 0 0", i,
                         bus_if.rsp_valid, bus_if.rsp_rdata, bus_if.req_ready, mem_rd, ref_mem[9]);
            end
        end
        cur_addr = 6'h0A;
        bus_if.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus_if.rsp_ready = 1'b0;
        // Handshake edge, then accept edge, then RdLat edges to the response.
        lat = 0;
        while (!bus_if.rsp_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
            if (lat == 1) bus_if.req_valid = 1'b0;
        end
        checks++;
        if (lat !== RdLat + 1 || bus_if.rsp_rdata !== ref_mem[10]) begin
            errors++;
            $display("FAIL bp_second got lat=%0d d=%h want lat=%0d d=%h",
                     lat, bus_if.rsp_rdata, RdLat + 1, ref_mem[10]);
        end
        bus_if.req_valid = 1'b0;
        @(negedge clk);
        bus_if.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus_if.rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int lat, wrs, rds;
        logic [63:0] rd;
        logic er;
        bit ok;
        issue(1'b1, 6'h3F, 64'hFFFF_0000_FFFF_0000, lat, rd, er, wrs, rds, ok);
        ref_mem[63] = 64'hFFFF_0000_FFFF_0000;
        issue(1'b1, 6'h00, 64'h1, lat, rd, er, wrs, rds, ok);
        ref_mem[0] = 64'h1;
        issue(1'b0, 6'h3F, 64'h0, lat, rd, er, wrs, rds, ok);
        checks++;
        if (!ok || rd !== 64'hFFFF_0000_FFFF_0000) begin
            errors++;
            $display("FAIL b2b_rd3f got %h ok=%0d want ffff0000ffff0000", rd, ok);
        end
        issue(1'b0, 6'h00, 64'h0, lat, rd, er, wrs, rds, ok);
        checks++;
        if (!ok || rd !== 64'h1) begin
            errors++;
            $display("FAIL b2b_rd00 got %h ok=%0d want 1", rd, ok);
        end
    endtask

    task automatic test_reset_abort();
        int lat, wrs, rds;
        logic [63:0] rd;
        logic er;
        bit ok;
        bit seen = 1'b0;
        cur_addr = 6'h02;
        @(negedge clk);
        bus_if.req_valid = 1'b1;
        bus_if.req_we    = 1'b1;
        bus_if.req_addr  = 6'h02;
        bus_if.req_wdata = 64'h2222_2222_2222_2222;
        @(posedge clk);
        #1 bus_if.req_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (mem_wr !== 1'b1) begin
            errors++;
            $display("FAIL abort_strobe_on MemWr got %b want 1", mem_wr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_wr !== 1'b0 || bus_oe !== 1'b0 || bus_if.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_drop got wr=%b oe=%b v=%b want 0 0 0",
                     mem_wr, bus_oe, bus_if.rsp_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus_if.rsp_valid || mem_wr) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_rsp got activity=%b want 0", seen);
        end
        issue(1'b1, 6'h02, 64'h0202_0202_5A5A_A5A5, lat, rd, er, wrs, rds, ok);
        ref_mem[2] = 64'h0202_0202_5A5A_A5A5;
        issue(1'b0, 6'h02, 64'h0, lat, rd, er, wrs, rds, ok);
        checks++;
        if (!ok || lat !== RdLat || rd !== ref_mem[2]) begin
            errors++;
            $display("FAIL abort_recover got lat=%0d d=%h want %0d %h", lat, rd, RdLat, ref_mem[2]);
        end
    endtask

`ifdef MEM_ACCESS_WRVERIFY_EN
    task automatic test_wrverify();
        int lat, wrs, rds;
        logic [63:0] rd;
        logic er;
        bit ok;
        corrupt_en = 1'b1;
        issue(1'b1, 6'h07, 64'hA5, lat, rd, er, wrs, rds, ok);
        ref_mem[7] = 64'hA5;
        checks++;
        if (!ok || er !== 1'b1 || rd !== 64'hA4) begin
            errors++;
            $display("FAIL verify_bad got err=%b d=%h want 1 a4", er, rd);
        end
        issue(1'b1, 6'h08, 64'h5A5A, lat, rd, er, wrs, rds, ok);
        ref_mem[8] = 64'h5A5A;
        checks++;
        if (!ok || er !== 1'b0 || rd !== 64'h5A5A || lat !== 2 * AC + 4) begin
            errors++;
            $display("FAIL verify_clean got err=%b d=%h lat=%0d want 0 5a5a %0d",
                     er, rd, lat, 2 * AC + 4);
        end
        corrupt_en = 1'b0;
    endtask
`endif

    task automatic test_random();
        int lat, wrs, rds;
        logic [63:0] rd, d, exp_d;
        logic [5:0] a;
        logic we, er;
        bit ok;
        for (int i = 0; i < 24; i++) begin
            we = 1'($urandom_range(0, 1));
            a  = 6'($urandom_range(0, 63));
            d  = {$urandom, $urandom};
            issue(we, a, d, lat, rd, er, wrs, rds, ok);
            if (we) ref_mem[a] = d;
            exp_d = (we && !Verify) ? 64'h0 : ref_mem[a];
            checks++;
            if (!ok || lat !== (we ? WrLat : RdLat) || rd !== exp_d || er !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d we=%b a=%h got lat=%0d d=%h err=%b want lat=%0d d=%h err=0",
                         i, we, a, lat, rd, er, we ? WrLat : RdLat, exp_d);
            end
        end
    endtask

    task automatic test_bus_invariants();
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL bus_invariants got %0d violations want 0", viol);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 64'h0;
            ref_mem[i] = 64'h0;
        end
        bus_if.req_valid = 1'b0;
        bus_if.req_we    = 1'b0;
        bus_if.req_addr  = '0;
        bus_if.req_wdata = '0;
        bus_if.rsp_ready = 1'b0;
        test_reset();
        test_write_read();
        test_backpressure();
        test_back_to_back();
        test_reset_abort();
`ifdef MEM_ACCESS_WRVERIFY_EN
        test_wrverify();
`endif
        test_random();
        test_bus_invariants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
